// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: EX operand forwarding, load-use
// stalls, branch flushes, a fixed-latency mult/div stall FSM and perf counters.

module phc_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_en,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        sel
);
    // EX/MEM is the younger producer, so it wins over MEM/WB
    always_comb begin
        sel = 2'b00;
        if (mem_en && mem_rd != '0 && mem_rd == src)
            sel = 2'b10;
        else if (wb_en && wb_rd != '0 && wb_rd == src)
            sel = 2'b01;
    end
endmodule

module pipe_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_muldiv,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_pcsrc,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int NUM_OPS = 2;

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t                      state, state_nxt;
    logic [7:0]                     md_cnt, md_cnt_nxt;
    logic [NUM_OPS-1:0][REG_AW-1:0] op_src;
    logic [NUM_OPS-1:0][1:0]        op_sel;
    logic                           load_use, busy, stall;

    // operand 0 = A (rs), operand 1 = B (rt)
    assign op_src = {ex_rt, ex_rs};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        phc_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
            .src    (op_src[g]),
            .mem_en (mem_valid & mem_regwrite),
            .mem_rd (mem_rd),
            .wb_en  (wb_valid & wb_regwrite),
            .wb_rd  (wb_rd),
            .sel    (op_sel[g])
        );
    end

    assign load_use = ex_valid & ex_memread & ex_regwrite & (ex_rd != '0) & id_valid &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));
    assign busy  = (state == BUSY);
    // a taken branch overrides every stall source
    assign stall = ~mem_pcsrc & (load_use | busy);

    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            IDLE: if (id_valid && id_muldiv && !load_use && !mem_pcsrc) begin
                state_nxt  = BUSY;
                md_cnt_nxt = 8'(MD_LAT - 1);
            end
            BUSY: if (mem_pcsrc || md_cnt == 8'd0) begin
                state_nxt  = IDLE;
                md_cnt_nxt = 8'd0;
            end else begin
                md_cnt_nxt = md_cnt - 8'd1;
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            md_cnt    <= 8'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (mem_pcsrc && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // combinational outputs are forced low while reset is asserted
    assign stall_pc    = rst_n & stall;
    assign stall_ifid  = rst_n & stall;
    assign bubble_idex = rst_n & stall;
    assign flush_ifid  = rst_n & mem_pcsrc;
    assign flush_idex  = rst_n & mem_pcsrc;
    assign flush_exmem = rst_n & mem_pcsrc;
    assign md_busy     = rst_n & busy;
    assign fwd_a       = rst_n ? op_sel[0] : 2'b00;
    assign fwd_b       = rst_n ? op_sel[1] : 2'b00;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for the combinational
// decode plus hand sequences for mult/div, flush, reset and saturation.

module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt, id_muldiv;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       ex_valid, ex_regwrite, ex_memread;
    logic       mem_valid, mem_regwrite, mem_pcsrc;
    logic       wb_valid, wb_regwrite;

    logic        stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem, md_busy;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s4_pc, s4_ifid, s4_bub, f4_ifid, f4_idex, f4_exmem, md4_busy;
    logic [1:0]  fa4, fb4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .MD_LAT(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_muldiv(id_muldiv),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_pcsrc(mem_pcsrc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // narrow-counter instance for the saturation corner
    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .MD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_muldiv(id_muldiv),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_pcsrc(mem_pcsrc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .stall_pc(s4_pc), .stall_ifid(s4_ifid), .bubble_idex(s4_bub),
        .flush_ifid(f4_ifid), .flush_idex(f4_idex), .flush_exmem(f4_exmem),
        .fwd_a(fa4), .fwd_b(fb4), .md_busy(md4_busy),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    typedef struct {
        logic       id_v;
        logic [4:0] id_rs, id_rt;
        logic [1:0] id_use;   // {use_rs, use_rt}
        logic [2:0] ex_ctl;   // {valid, regwrite, memread}
        logic [4:0] ex_rs, ex_rt, ex_rd;
        logic [2:0] mem_ctl;  // {valid, regwrite, pcsrc}
        logic [4:0] mem_rd;
        logic [1:0] wb_ctl;   // {valid, regwrite}
        logic [4:0] wb_rd;
        logic       e_stall, e_flush;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_muldiv = 0;
        ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_valid = 0; mem_rd = 0; mem_regwrite = 0; mem_pcsrc = 0;
        wb_valid = 0; wb_rd = 0; wb_regwrite = 0;
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.id_v; id_rs = v.id_rs; id_rt = v.id_rt;
        {id_use_rs, id_use_rt} = v.id_use;
        {ex_valid, ex_regwrite, ex_memread} = v.ex_ctl;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
        {mem_valid, mem_regwrite, mem_pcsrc} = v.mem_ctl;
        mem_rd = v.mem_rd;
        {wb_valid, wb_regwrite} = v.wb_ctl;
        wb_rd = v.wb_rd;
        id_muldiv = 0;
    endtask

    task automatic set_loaduse();
        id_valid = 1; id_rs = 5; id_use_rs = 1;
        ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 5;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_in();
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [63:0] all_outs();
        return {21'd0, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex, flush_exmem,
                fwd_a, fwd_b, md_busy, stall_cnt, flush_cnt};
    endfunction

    int exp_st, exp_fl;

    initial begin
        //          id_v rs rt use    ex_ctl  ers ert erd mem_ctl mrd wb_ctl wrd  st fl fa     fb
        vt[0]  = '{1, 5, 0, 2'b10, 3'b111, 0, 0, 5, 3'b000, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00};
        vt[1]  = '{1, 1, 5, 2'b01, 3'b111, 0, 0, 5, 3'b000, 0, 2'b00, 0, 1, 0, 2'b00, 2'b00};
        vt[2]  = '{1, 1, 5, 2'b10, 3'b111, 0, 0, 5, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00};
        vt[3]  = '{1, 0, 0, 2'b11, 3'b111, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00};
        vt[4]  = '{1, 5, 0, 2'b10, 3'b110, 0, 0, 5, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00};
        vt[5]  = '{0, 5, 0, 2'b10, 3'b111, 0, 0, 5, 3'b000, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00};
        vt[6]  = '{0, 0, 0, 2'b00, 3'b100, 7, 7, 0, 3'b110, 7, 2'b11, 7, 0, 0, 2'b10, 2'b10};
        vt[7]  = '{0, 0, 0, 2'b00, 3'b100, 7, 7, 0, 3'b100, 7, 2'b11, 7, 0, 0, 2'b01, 2'b01};
        vt[8]  = '{0, 0, 0, 2'b00, 3'b100, 7, 7, 0, 3'b110, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00};
        vt[9]  = '{0, 0, 0, 2'b00, 3'b100, 0, 0, 0, 3'b110, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00};
        vt[10] = '{0, 0, 0, 2'b00, 3'b100, 3, 4, 0, 3'b110, 3, 2'b11, 4, 0, 0, 2'b10, 2'b01};
        vt[11] = '{0, 0, 0, 2'b00, 3'b100, 3, 9, 0, 3'b010, 3, 2'b11, 3, 0, 0, 2'b01, 2'b00};
        vt[12] = '{1, 5, 0, 2'b10, 3'b111, 0, 0, 5, 3'b001, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00};
        vt[13] = '{0, 0, 0, 2'b00, 3'b100, 7, 7, 0, 3'b000, 0, 2'b01, 7, 0, 0, 2'b00, 2'b00};

        // asynchronous reset holds every output low even with hazards present
        rst_n = 1;
        clear_in();
        #2 rst_n = 0;
        set_loaduse();
        mem_pcsrc = 1; mem_valid = 1; mem_regwrite = 1; mem_rd = 5; ex_rs = 5; id_muldiv = 1;
        #1 chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1;
        clear_in();

        // combinational table, one clock per vector
        exp_st = 0; exp_fl = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(vt[i]);
            #1;
            chk($sformatf("v%0d_stall", i), {61'd0, stall_pc, stall_ifid, bubble_idex},
                {61'd0, {3{vt[i].e_stall}}});
            chk($sformatf("v%0d_flush", i), {61'd0, flush_ifid, flush_idex, flush_exmem},
                {61'd0, {3{vt[i].e_flush}}});
            chk($sformatf("v%0d_fwd", i), {60'd0, fwd_a, fwd_b}, {60'd0, vt[i].e_fa, vt[i].e_fb});
            exp_st += int'(vt[i].e_stall);
            exp_fl += int'(vt[i].e_flush);
        end
        @(negedge clk);
        clear_in();
        chk("table_stall_cnt", 64'(stall_cnt), 64'(exp_st));
        chk("table_flush_cnt", 64'(flush_cnt), 64'(exp_fl));

        // single load-use bubble
        do_reset();
        set_loaduse();
        #1 chk("lu_stall", 64'(stall_pc), 64'd1);
        @(negedge clk);
        clear_in();
        #1 chk("lu_released", 64'(stall_pc), 64'd0);
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);

        // mult issue: no stall on issue, then exactly 4 busy/stall cycles
        do_reset();
        id_valid = 1; id_muldiv = 1;
        #1 chk("md_issue_nostall", 64'(stall_pc), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_in();
            #1 chk($sformatf("md_busy_c%0d", c), {62'd0, md_busy, stall_pc}, 64'd3);
        end
        @(negedge clk);
        #1 chk("md_done", {62'd0, md_busy, stall_pc}, 64'd0);
        chk("md_stall_cnt", 64'(stall_cnt), 64'd4);

        // load-use during BUSY adds no cycles
        do_reset();
        id_valid = 1; id_muldiv = 1;
        @(negedge clk);
        clear_in();
        set_loaduse();
        for (int c = 0; c < 3; c++) @(negedge clk);
        #1 chk("md_lu_last_busy", 64'(md_busy), 64'd1);
        @(negedge clk);
        clear_in();
        #1 chk("md_lu_done", 64'(md_busy), 64'd0);
        chk("md_lu_stall_cnt", 64'(stall_cnt), 64'd4);

        // branch in first BUSY cycle squashes the mult
        do_reset();
        id_valid = 1; id_muldiv = 1;
        @(negedge clk);
        clear_in();
        mem_pcsrc = 1;
        #1 chk("md_flush_outs", {58'd0, stall_pc, stall_ifid, bubble_idex, flush_ifid, flush_idex,
                                 flush_exmem}, 64'h7);
        @(negedge clk);
        clear_in();
        #1 chk("md_squashed", {62'd0, md_busy, stall_pc}, 64'd0);
        chk("md_sq_cnts", {32'(stall_cnt), 32'(flush_cnt)}, {32'd0, 32'd1});

        // reset pulse mid-BUSY
        do_reset();
        id_valid = 1; id_muldiv = 1;
        @(negedge clk);
        clear_in();
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk("md_rst_outs", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1 chk("md_rst_resume", {62'd0, md_busy, stall_pc}, 64'd0);

        // counter saturation on the 4-bit instance
        do_reset();
        set_loaduse();
        for (int c = 0; c < 20; c++) @(negedge clk);
        clear_in();
        chk("sat_cnt4", 64'(stall_cnt4), 64'd15);
        chk("sat_cnt16", 64'(stall_cnt), 64'd20);
        @(negedge clk);
        chk("sat_hold", 64'(stall_cnt4), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line:
  REG_AW  5   register-address width
  CNT_W   16  width of the performance counters
  MD_LAT  4   multiply/divide stall length in cycles; legal range 1..255
REQ-002 The block SHALL have these ports, one per line:
  clk           in   1       single clock; all state changes on its rising edge
  rst_n         in   1       asynchronous, active-low reset
  id_valid      in   1       the IF/ID register holds a live instruction
  id_rs         in   REG_AW  rs field of the instruction in ID
  id_rt         in   REG_AW  rt field of the instruction in ID
  id_use_rs     in   1       the ID instruction reads rs
  id_use_rt     in   1       the ID instruction reads rt
  id_muldiv     in   1       the ID instruction is a mult or div
  ex_valid      in   1       the ID/EX register holds a live instruction
  ex_rs         in   REG_AW  rs field of the instruction in EX
  ex_rt         in   REG_AW  rt field of the instruction in EX
  ex_rd         in   REG_AW  destination register of the instruction in EX
  ex_regwrite   in   1       the EX instruction writes a register
  ex_memread    in   1       the EX instruction is a load
  mem_valid     in   1       the EX/MEM register holds a live instruction
  mem_rd        in   REG_AW  destination register of the instruction in MEM
  mem_regwrite  in   1       the MEM instruction writes a register
  mem_pcsrc     in   1       a taken branch is resolved in MEM
  wb_valid      in   1       the MEM/WB register holds a live instruction
  wb_rd         in   REG_AW  destination register of the instruction in WB
  wb_regwrite   in   1       the WB instruction writes a register
  stall_pc      out  1       hold the PC
  stall_ifid    out  1       hold the IF/ID register
  bubble_idex   out  1       load a NOP into the ID/EX register
  flush_ifid    out  1       clear the IF/ID register
  flush_idex    out  1       clear the ID/EX register
  flush_exmem   out  1       clear the EX/MEM register
  fwd_a         out  2       operand A source for EX: 00 register file, 10 EX/MEM, 01 MEM/WB
  fwd_b         out  2       operand B source for EX, same encoding as fwd_a
  md_busy       out  1       the multiply/divide unit is occupied
  stall_cnt     out  CNT_W   count of stall cycles
  flush_cnt     out  CNT_W   count of flush cycles

Function
REQ-003 Forwarding (combinational):
  - fwd_a SHALL be 10 when mem_valid & mem_regwrite & mem_rd!=0 & mem_rd==ex_rs.
  - Otherwise fwd_a SHALL be 01 when wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs.
  - Otherwise fwd_a SHALL be 00.
  - fwd_b SHALL follow the same rules using ex_rt.
  - The value 11 SHALL never be driven.
REQ-004 A load-use hazard SHALL exist when all of the following hold:
  - ex_valid & ex_memread & ex_regwrite & ex_rd!=0 & id_valid
  - (id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)
REQ-005 During a load-use hazard, stall_pc, stall_ifid and bubble_idex SHALL be 1 in the same cycle (combinational), giving exactly one bubble per hazard.
REQ-006 When mem_pcsrc=1:
  - flush_ifid, flush_idex and flush_exmem SHALL be 1.
  - stall_pc, stall_ifid and bubble_idex SHALL be 0, because flush has priority over all stall sources.
REQ-007 The multiply/divide FSM SHALL have two states: IDLE and BUSY, with an 8-bit down-counter md_cnt.
REQ-008 IDLE to BUSY: taken at the clock edge when id_valid & id_muldiv & no load-use hazard & mem_pcsrc=0; md_cnt SHALL load MD_LAT-1. The issuing instruction itself SHALL not be stalled.
REQ-009 In BUSY:
  - md_busy, stall_pc, stall_ifid and bubble_idex SHALL be 1.
  - md_cnt SHALL decrement each cycle.
  - The FSM SHALL return to IDLE after the cycle in which md_cnt==0, giving exactly MD_LAT stall cycles.
REQ-010 mem_pcsrc=1 in BUSY SHALL force IDLE and md_cnt=0 at the next edge (the mult/div is squashed); stall outputs SHALL be 0 in that cycle per REQ-006.
REQ-011 A load-use hazard arising while BUSY SHALL add no extra cycles; the stall outputs are the OR of both sources.
REQ-012 stall_cnt SHALL increment by 1 at each edge where stall_pc=1, saturating at all-ones.
REQ-013 flush_cnt SHALL increment by 1 at each edge where mem_pcsrc=1, saturating at all-ones.
REQ-014 Register 0 SHALL never trigger forwarding or a load-use stall.

Reset
REQ-015 While rst_n=0 (asynchronously, independent of clk), the block SHALL hold:
  - FSM in IDLE, md_cnt=0, stall_cnt=0, flush_cnt=0.
  - Every output driven to 0.
REQ-016 Deasserting rst_n during BUSY SHALL resume in IDLE with no residual stall.

Verification
REQ-017 lw $5 in EX (ex_memread=1, ex_rd=5), ID reads rs=5 -> stall_pc=stall_ifid=bubble_idex=1 for one cycle; stall_cnt=1.
REQ-018 ex_rs=ex_rt=7, mem_rd=7 and wb_rd=7 with both regwrite=1 -> fwd_a=fwd_b=10; repeat with mem_regwrite=0 -> 01; repeat with all rd=0 -> 00.
REQ-019 MD_LAT=4, mult issued from ID -> md_busy=1 for exactly 4 cycles starting the next cycle; stall_cnt=4 afterwards.
REQ-020 mem_pcsrc=1 together with a load-use hazard -> all three flushes=1, all stalls=0, flush_cnt=1, stall_cnt unchanged.
REQ-021 mem_pcsrc=1 in the first BUSY cycle -> IDLE next cycle, md_busy=0; rst_n pulsed low mid-BUSY -> all outputs 0 immediately.
REQ-022 Preload stall_cnt near all-ones with CNT_W=4, then hold 20 stall cycles -> stall_cnt=15 and no wrap.
